// File: rtl/adc_responder.sv
// adc_responder: synthesizable stand-in for the serial safety ADC. It answers a
// CNV fall with a conversion delay, then shifts a zero-led frame carrying a
// 12-bit sample MSB-first on adc_sdo. It also keeps frame statistics and
// sticky protocol-error flags.
module adc_responder #(
  parameter int          CONV_CYCLES = 16,     // busy clocks after CNV fall (1..255)
  parameter int          LEAD_ZEROS  = 3,      // zero bits ahead of data MSB (0..7)
  parameter logic [11:0] RAMP_STEP   = 12'd1   // ramp increment per ramp-sourced frame
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        adc_convert,
  input  logic        adc_sck,
  input  logic        sample_sel,
  input  logic [11:0] sample_in,
  input  logic        err_clr,
  output logic        adc_sdo,
  output logic        busy,
  output logic        frame_done,
  output logic [11:0] last_value,
  output logic [4:0]  last_sck_count,
  output logic [1:0]  err_flags
);

  localparam int FW = LEAD_ZEROS + 12;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t         state;
  logic           cnv_q;
  logic           sck_q;
  logic [7:0]     conv_cnt;
  logic [FW-1:0]  shreg;
  logic [4:0]     sck_cnt;
  logic [11:0]    ramp;
  logic           ramp_src;

  logic           cnv_fall;
  logic           cnv_rise;
  logic           sck_rise;
  logic           in_frame;
  logic [11:0]    word_sel;
  logic [FW-1:0]  frame_load;
  logic [4:0]     sck_cnt_inc;
  logic [1:0]     err_new;

  // Edge detection, word selection, saturating sck count and new error events
  always_comb begin
    cnv_fall    = cnv_q & ~adc_convert;
    cnv_rise    = ~cnv_q & adc_convert;
    sck_rise    = ~sck_q & adc_sck;
    in_frame    = (state == CONV) || (state == SHIFT);
    word_sel    = sample_sel ? ramp : sample_in;
    frame_load  = FW'(word_sel);
    sck_cnt_inc = sck_cnt;
    if (sck_rise && in_frame && (sck_cnt != 5'd31)) begin
      sck_cnt_inc = sck_cnt + 5'd1;
    end
    err_new    = 2'b00;
    err_new[0] = sck_rise && (state == CONV);
    err_new[1] = sck_rise && ((state == IDLE) || (state == DONE));
  end

  // Protocol FSM with registered outputs; frame statistics and the ramp are
  // committed on the edge that enters DONE so they are visible with frame_done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnv_q          <= 1'b1;
      sck_q          <= 1'b0;
      conv_cnt       <= '0;
      shreg          <= '0;
      sck_cnt        <= '0;
      ramp           <= '0;
      ramp_src       <= 1'b0;
      adc_sdo        <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      last_value     <= '0;
      last_sck_count <= '0;
      err_flags      <= '0;
    end else begin
      cnv_q      <= adc_convert;
      sck_q      <= adc_sck;
      frame_done <= 1'b0;
      // A new error event overrides a coincident clear
      err_flags  <= (err_clr ? 2'b00 : err_flags) | err_new;

      case (state)
        IDLE: begin
          adc_sdo <= 1'b0;
          busy    <= 1'b0;
          if (cnv_fall) begin
            shreg      <= frame_load;
            adc_sdo    <= frame_load[FW-1];
            last_value <= word_sel;
            ramp_src   <= sample_sel;
            sck_cnt    <= '0;
            conv_cnt   <= 8'(CONV_CYCLES - 1);
            busy       <= 1'b1;
            state      <= CONV;
          end
        end

        CONV: begin
          // sck rises here are counted and flagged but never shift the frame
          sck_cnt <= sck_cnt_inc;
          if (cnv_rise) begin
            state          <= DONE;
            busy           <= 1'b0;
            adc_sdo        <= 1'b0;
            frame_done     <= 1'b1;
            last_sck_count <= sck_cnt_inc;
            if (ramp_src) ramp <= ramp + RAMP_STEP;
          end else if (conv_cnt == 8'd0) begin
            state <= SHIFT;
            busy  <= 1'b0;
          end else begin
            conv_cnt <= conv_cnt - 8'd1;
          end
        end

        SHIFT: begin
          sck_cnt <= sck_cnt_inc;
          if (cnv_rise) begin
            state          <= DONE;
            adc_sdo        <= 1'b0;
            frame_done     <= 1'b1;
            last_sck_count <= sck_cnt_inc;
            if (ramp_src) ramp <= ramp + RAMP_STEP;
          end else if (sck_rise) begin
            // Zero fill keeps adc_sdo low once the frame is exhausted
            shreg   <= shreg << 1;
            adc_sdo <= shreg[FW-2];
          end
        end

        default: begin
          // DONE: the one-clock frame_done window, then back to IDLE
          adc_sdo <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed test of adc_responder. Inputs are driven on the
// falling clock edge and outputs are sampled there, away from the active edge.
module tb_adc_responder;

  logic        clk;
  logic        rstn;
  logic        adc_convert;
  logic        adc_sck;
  logic        sample_sel;
  logic [11:0] sample_in;
  logic        err_clr;
  logic        adc_sdo;
  logic        busy;
  logic        frame_done;
  logic [11:0] last_value;
  logic [4:0]  last_sck_count;
  logic [1:0]  err_flags;

  int checks;
  int passes;

  adc_responder #(
    .CONV_CYCLES(16),
    .LEAD_ZEROS (3),
    .RAMP_STEP  (12'd1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .adc_convert   (adc_convert),
    .adc_sck       (adc_sck),
    .sample_sel    (sample_sel),
    .sample_in     (sample_in),
    .err_clr       (err_clr),
    .adc_sdo       (adc_sdo),
    .busy          (busy),
    .frame_done    (frame_done),
    .last_value    (last_value),
    .last_sck_count(last_sck_count),
    .err_flags     (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller-style frame: CNV low 22 clks (optional stray sck pulse at
  // clock err_at), 16 sck pulses capturing adc_sdo at each rise, CNV high.
  // Returns at the falling edge where the DUT sits in DONE.
  task automatic run_frame(input logic sel, input logic [11:0] word,
                           input int err_at, output logic [11:0] got);
    logic [16:0] caps;
    caps       = '0;
    sample_sel = sel;
    sample_in  = word;
    @(negedge clk);
    adc_convert = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      adc_sck = (i == err_at);
    end
    for (int k = 1; k <= 16; k++) begin
      caps[k] = adc_sdo;
      adc_sck = 1'b1;
      @(negedge clk);
      adc_sck = 1'b0;
      @(negedge clk);
    end
    adc_convert = 1'b1;
    @(negedge clk);
    got = '0;
    for (int k = 4; k <= 15; k++) got = {got[10:0], caps[k]};
  endtask

  // Short frame aborted during CONV; used where only the sampled word matters
  task automatic quick_frame(input logic sel, input logic [11:0] word);
    sample_sel = sel;
    sample_in  = word;
    @(negedge clk);
    adc_convert = 1'b0;
    @(negedge clk);
    @(negedge clk);
    adc_convert = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (adc_sdo !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", adc_sdo); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else passes++;
    checks++; if (last_value !== 12'h000) $display("FAIL reset_last_value: got %h expected 000", last_value); else passes++;
    checks++; if (last_sck_count !== 5'd0) $display("FAIL reset_sck_count: got %0d expected 0", last_sck_count); else passes++;
    checks++; if (err_flags !== 2'b00) $display("FAIL reset_err_flags: got %b expected 00", err_flags); else passes++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_controller_frame();
    logic [11:0] got;
    run_frame(1'b0, 12'hA5C, -1, got);
    checks++; if (got !== 12'hA5C) $display("FAIL frame_word: got %h expected a5c", got); else passes++;
    checks++; if (frame_done !== 1'b1) $display("FAIL frame_done_pulse: got %b expected 1", frame_done); else passes++;
    checks++; if (last_sck_count !== 5'd16) $display("FAIL frame_sck_count: got %0d expected 16", last_sck_count); else passes++;
    checks++; if (last_value !== 12'hA5C) $display("FAIL frame_last_value: got %h expected a5c", last_value); else passes++;
    checks++; if (err_flags !== 2'b00) $display("FAIL frame_err_flags: got %b expected 00", err_flags); else passes++;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) $display("FAIL frame_done_single: got %b expected 0", frame_done); else passes++;
  endtask

  task automatic test_busy_timing();
    sample_sel = 1'b0;
    sample_in  = 12'h111;
    @(negedge clk);
    adc_convert = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy); else passes++;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL busy_last_cycle: got %b expected 1", busy); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL busy_fall: got %b expected 0", busy); else passes++;
    adc_convert = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sck_in_conv();
    logic [11:0] got;
    run_frame(1'b0, 12'h3C7, 5, got);
    checks++; if (got !== 12'h3C7) $display("FAIL conv_err_word: got %h expected 3c7", got); else passes++;
    checks++; if (err_flags !== 2'b01) $display("FAIL conv_err_flags: got %b expected 01", err_flags); else passes++;
    checks++; if (last_sck_count !== 5'd17) $display("FAIL conv_err_sck_count: got %0d expected 17", last_sck_count); else passes++;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_flags !== 2'b00) $display("FAIL conv_err_clear: got %b expected 00", err_flags); else passes++;
  endtask

  task automatic test_sck_cnv_high();
    @(negedge clk);
    adc_sck = 1'b1;
    @(negedge clk);
    adc_sck = 1'b0;
    checks++; if (err_flags !== 2'b10) $display("FAIL idle_err_flags: got %b expected 10", err_flags); else passes++;
    checks++; if (adc_sdo !== 1'b0) $display("FAIL idle_sdo: got %b expected 0", adc_sdo); else passes++;
    @(negedge clk);
    adc_sck = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    adc_sck = 1'b0;
    err_clr = 1'b0;
    checks++; if (err_flags !== 2'b10) $display("FAIL clr_vs_new_err: got %b expected 10", err_flags); else passes++;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_flags !== 2'b00) $display("FAIL idle_err_clear: got %b expected 00", err_flags); else passes++;
  endtask

  task automatic test_abort_conv();
    sample_sel = 1'b0;
    sample_in  = 12'h0F0;
    @(negedge clk);
    adc_convert = 1'b0;
    repeat (3) @(negedge clk);
    adc_convert = 1'b1;
    @(negedge clk);
    checks++; if (frame_done !== 1'b1) $display("FAIL abort_frame_done: got %b expected 1", frame_done); else passes++;
    checks++; if (last_sck_count !== 5'd0) $display("FAIL abort_sck_count: got %0d expected 0", last_sck_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passes++;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) $display("FAIL abort_done_single: got %b expected 0", frame_done); else passes++;
    // Back in IDLE: a new conversion is accepted straight away
    quick_frame(1'b0, 12'h5A5);
    checks++; if (last_value !== 12'h5A5) $display("FAIL abort_then_idle: got %h expected 5a5", last_value); else passes++;
  endtask

  task automatic test_back_to_back_ramp();
    logic [11:0] exp_word;
    sample_sel = 1'b1;
    for (int i = 0; i < 4098; i++) begin
      exp_word = i[11:0];
      @(negedge clk);
      adc_convert = 1'b0;
      @(negedge clk);
      checks++; if (last_value !== exp_word) $display("FAIL ramp_word_%0d: got %h expected %h", i, last_value, exp_word); else passes++;
      @(negedge clk);
      adc_convert = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    // An external-sourced frame must leave the ramp alone
    quick_frame(1'b0, 12'hABC);
    quick_frame(1'b1, 12'h000);
    checks++; if (last_value !== 12'h002) $display("FAIL ramp_hold_on_ext: got %h expected 002", last_value); else passes++;
  endtask

  task automatic test_reset_mid_shift();
    logic [11:0] got;
    logic        seen_done;
    run_frame(1'b0, 12'h123, -1, got);
    @(negedge clk);
    adc_sck = 1'b1;
    @(negedge clk);
    adc_sck = 1'b0;
    sample_sel = 1'b0;
    sample_in  = 12'hFFF;
    @(negedge clk);
    adc_convert = 1'b0;
    repeat (22) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      adc_sck = 1'b1;
      @(negedge clk);
      adc_sck = 1'b0;
      @(negedge clk);
    end
    checks++; if (adc_sdo !== 1'b1) $display("FAIL midshift_sdo: got %b expected 1", adc_sdo); else passes++;
    rstn = 1'b0;
    #1;
    checks++; if (adc_sdo !== 1'b0) $display("FAIL rst_sdo: got %b expected 0", adc_sdo); else passes++;
    checks++; if (last_value !== 12'h000) $display("FAIL rst_last_value: got %h expected 000", last_value); else passes++;
    checks++; if (last_sck_count !== 5'd0) $display("FAIL rst_sck_count: got %0d expected 0", last_sck_count); else passes++;
    checks++; if (err_flags !== 2'b00) $display("FAIL rst_err_flags: got %b expected 00", err_flags); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
    adc_convert = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen_done = seen_done | frame_done;
    end
    checks++; if (seen_done !== 1'b0) $display("FAIL rst_no_frame_done: got %b expected 0", seen_done); else passes++;
    quick_frame(1'b1, 12'h000);
    checks++; if (last_value !== 12'h000) $display("FAIL rst_ramp_cleared: got %h expected 000", last_value); else passes++;
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    rstn        = 1'b0;
    adc_convert = 1'b1;
    adc_sck     = 1'b0;
    sample_sel  = 1'b0;
    sample_in   = 12'h000;
    err_clr     = 1'b0;
    test_reset();
    test_controller_frame();
    test_busy_timing();
    test_sck_in_conv();
    test_sck_cnv_high();
    test_abort_conv();
    test_back_to_back_ramp();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
